// File: rtl/regfile_wb_ctrl.sv
`timescale 1ns/1ps
// regfile_wb_ctrl: owns the single regfile write port.
// Arbitrates MDU > LSU > ALU results into one registered write per cycle and
// keeps a per-register busy scoreboard for ID hazard detection.
// Optional macro WB_BYPASS_EN adds forwarding of the in-flight write to ID and
// relaxes hazard_o for sources satisfied by that forward.
module regfile_wb_ctrl #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_NUM = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               alu_valid_i,
    input  logic [4:0]         alu_rd_i,
    input  logic [DATA_W-1:0]  alu_data_i,
    output logic               alu_ready_o,

    input  logic               lsu_valid_i,
    input  logic [4:0]         lsu_rd_i,
    input  logic [DATA_W-1:0]  lsu_data_i,
    output logic               lsu_ready_o,

    input  logic               mdu_valid_i,
    input  logic [4:0]         mdu_rd_i,
    input  logic [DATA_W-1:0]  mdu_data_i,
    output logic               mdu_ready_o,

    input  logic               issue_valid_i,
    input  logic [4:0]         issue_rd_i,
    input  logic [4:0]         chk_rs1_i,
    input  logic [4:0]         chk_rs2_i,
    output logic               hazard_o,

    input  logic               flush_i,

    output logic [4:0]         waddr_o,
    output logic [DATA_W-1:0]  wdata_o,

`ifdef WB_BYPASS_EN
    input  logic [4:0]         fwd_raddr1_i,
    input  logic [4:0]         fwd_raddr2_i,
    output logic               fwd_hit1_o,
    output logic               fwd_hit2_o,
    output logic [DATA_W-1:0]  fwd_data1_o,
    output logic [DATA_W-1:0]  fwd_data2_o,
`endif

    output logic [REG_NUM-1:0] busy_o
);

    logic [4:0]         waddr_q, waddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [REG_NUM-1:0] busy_q, busy_d;
    logic               rs1_busy, rs2_busy;

    // Fixed-priority grant; nothing is granted while reset is asserted.
    always_comb begin
        mdu_ready_o = rst_i & mdu_valid_i;
        lsu_ready_o = rst_i & lsu_valid_i & ~mdu_valid_i;
        alu_ready_o = rst_i & alu_valid_i & ~lsu_valid_i & ~mdu_valid_i;
    end

    // Select the granted result; idle or r0 writes present address 0, data 0.
    always_comb begin
        waddr_d = '0;
        wdata_d = '0;
        if (mdu_ready_o) begin
            waddr_d = mdu_rd_i;
            wdata_d = mdu_data_i;
        end else if (lsu_ready_o) begin
            waddr_d = lsu_rd_i;
            wdata_d = lsu_data_i;
        end else if (alu_ready_o) begin
            waddr_d = alu_rd_i;
            wdata_d = alu_data_i;
        end
        if (waddr_d == '0) begin
            wdata_d = '0;
        end
    end

    // Scoreboard next state: flush/commit clear first, so a same-edge issue wins.
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else if (waddr_q != '0) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (issue_valid_i && (issue_rd_i != '0)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Write stage and scoreboard state; reset drops any pending write.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    // Hazard check; with bypass, a source fed by the in-flight write is not a hazard.
    always_comb begin
        rs1_busy = busy_q[chk_rs1_i];
        rs2_busy = busy_q[chk_rs2_i];
`ifdef WB_BYPASS_EN
        if ((waddr_q != '0) && (waddr_q == chk_rs1_i)) begin
            rs1_busy = 1'b0;
        end
        if ((waddr_q != '0) && (waddr_q == chk_rs2_i)) begin
            rs2_busy = 1'b0;
        end
`endif
        hazard_o = rs1_busy | rs2_busy | busy_q[issue_rd_i];
    end

`ifdef WB_BYPASS_EN
    // Forward the registered write to ID for same-cycle reads.
    always_comb begin
        fwd_hit1_o  = (waddr_q != '0) && (waddr_q == fwd_raddr1_i);
        fwd_hit2_o  = (waddr_q != '0) && (waddr_q == fwd_raddr2_i);
        fwd_data1_o = wdata_q;
        fwd_data2_o = wdata_q;
    end
`endif

    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
`timescale 1ns/1ps
// Testbench for regfile_wb_ctrl: directed stimulus, write scoreboard queue,
// independent monitor for writes, grants and source hold rules.
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        alu_valid_i = 1'b0, lsu_valid_i = 1'b0, mdu_valid_i = 1'b0;
    logic [4:0]  alu_rd_i = '0, lsu_rd_i = '0, mdu_rd_i = '0;
    logic [31:0] alu_data_i = '0, lsu_data_i = '0, mdu_data_i = '0;
    logic        alu_ready_o, lsu_ready_o, mdu_ready_o;
    logic        issue_valid_i = 1'b0;
    logic [4:0]  issue_rd_i = '0, chk_rs1_i = '0, chk_rs2_i = '0;
    logic        hazard_o;
    logic        flush_i = 1'b0;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic [31:0] busy_o;
`ifdef WB_BYPASS_EN
    logic [4:0]  fwd_raddr1_i = '0, fwd_raddr2_i = '0;
    logic        fwd_hit1_o, fwd_hit2_o;
    logic [31:0] fwd_data1_o, fwd_data2_o;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;
    wb_t exp_q[$];

    regfile_wb_ctrl #(.DATA_W(32), .REG_NUM(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .alu_valid_i  (alu_valid_i),
        .alu_rd_i     (alu_rd_i),
        .alu_data_i   (alu_data_i),
        .alu_ready_o  (alu_ready_o),
        .lsu_valid_i  (lsu_valid_i),
        .lsu_rd_i     (lsu_rd_i),
        .lsu_data_i   (lsu_data_i),
        .lsu_ready_o  (lsu_ready_o),
        .mdu_valid_i  (mdu_valid_i),
        .mdu_rd_i     (mdu_rd_i),
        .mdu_data_i   (mdu_data_i),
        .mdu_ready_o  (mdu_ready_o),
        .issue_valid_i(issue_valid_i),
        .issue_rd_i   (issue_rd_i),
        .chk_rs1_i    (chk_rs1_i),
        .chk_rs2_i    (chk_rs2_i),
        .hazard_o     (hazard_o),
        .flush_i      (flush_i),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
`ifdef WB_BYPASS_EN
        .fwd_raddr1_i (fwd_raddr1_i),
        .fwd_raddr2_i (fwd_raddr2_i),
        .fwd_hit1_o   (fwd_hit1_o),
        .fwd_hit2_o   (fwd_hit2_o),
        .fwd_data1_o  (fwd_data1_o),
        .fwd_data2_o  (fwd_data2_o),
`endif
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Monitor: pop expected writes, check idle data and the grant model.
    always @(negedge clk) begin
        wb_t e;
        if (waddr_o != '0) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected_addr", 32'(waddr_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wb_addr", 32'(waddr_o), 32'(e.addr));
                chk("wb_data", wdata_o, e.data);
            end
        end else begin
            chk("idle_data", wdata_o, 32'd0);
        end
        chk("mdu_ready", 32'(mdu_ready_o), 32'(rst_i & mdu_valid_i));
        chk("lsu_ready", 32'(lsu_ready_o), 32'(rst_i & lsu_valid_i & ~mdu_valid_i));
        chk("alu_ready", 32'(alu_ready_o),
            32'(rst_i & alu_valid_i & ~lsu_valid_i & ~mdu_valid_i));
    end

    // Source protocol: a waiting source keeps valid, rd and data stable.
    logic [2:0]  sv, sr;
    logic [4:0]  srd [3];
    logic [31:0] sd  [3];
    logic [2:0]  pv = '0, pr = '0;
    logic [4:0]  prd [3];
    logic [31:0] pd  [3];

    always_comb begin
        sv = {mdu_valid_i, lsu_valid_i, alu_valid_i};
        sr = {mdu_ready_o, lsu_ready_o, alu_ready_o};
        srd[0] = alu_rd_i;   srd[1] = lsu_rd_i;   srd[2] = mdu_rd_i;
        sd[0]  = alu_data_i; sd[1]  = lsu_data_i; sd[2]  = mdu_data_i;
    end

    always @(negedge clk) begin
        if (!rst_i) begin
            pv <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (pv[i] && !pr[i]) begin
                    chk("hold_valid", 32'(sv[i]), 32'd1);
                    chk("hold_rd", 32'(srd[i]), 32'(prd[i]));
                    chk("hold_data", sd[i], pd[i]);
                end
                prd[i] <= srd[i];
                pd[i]  <= sd[i];
            end
            pv <= sv;
            pr <= sr;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a, l, m;
        int   cyc;

        // Reset state
        #2;
        chk("rst_busy", busy_o, 32'd0);
        chk("rst_waddr", 32'(waddr_o), 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        step();
        rst_i = 1'b1;

        // Issue r3, ALU writes r3
        step();
        issue_valid_i = 1'b1; issue_rd_i = 5'd3;
        step();
        issue_valid_i = 1'b0; issue_rd_i = 5'd0;
        alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_data_i = 32'hDEADBEEF;
        exp_q.push_back('{addr: 5'd3, data: 32'hDEADBEEF});
        chk_rs1_i = 5'd3;
        sample();
        chk("a_alu_ready", 32'(alu_ready_o), 32'd1);
        chk("a_busy3_c2", 32'(busy_o[3]), 32'd1);
        chk("a_hazard_c2", 32'(hazard_o), 32'd1);
        step();
        alu_valid_i = 1'b0;
        sample();
        chk("a_busy3_c3", 32'(busy_o[3]), 32'd1);
`ifdef WB_BYPASS_EN
        chk("a_hazard_c3", 32'(hazard_o), 32'd0);
`else
        chk("a_hazard_c3", 32'(hazard_o), 32'd1);
`endif
        step();
        sample();
        chk("a_busy3_c4", 32'(busy_o[3]), 32'd0);
        chk("a_hazard_c4", 32'(hazard_o), 32'd0);
        chk_rs1_i = 5'd0;

        // rd=0 source and rd=0 issue have no effect
        step();
        alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'hFFFFFFFF;
        issue_valid_i = 1'b1; issue_rd_i = 5'd0;
        sample();
        chk("z_alu_ready", 32'(alu_ready_o), 32'd1);
        step();
        alu_valid_i = 1'b0; issue_valid_i = 1'b0;
        sample();
        chk("z_waddr", 32'(waddr_o), 32'd0);
        chk("z_wdata", wdata_o, 32'd0);
        chk("z_busy", busy_o, 32'd0);

        // Three sources at once: expect r4, r2, r1
        step();
        alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'h11110001;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd2; lsu_data_i = 32'h22220002;
        mdu_valid_i = 1'b1; mdu_rd_i = 5'd4; mdu_data_i = 32'h44440004;
        exp_q.push_back('{addr: 5'd4, data: 32'h44440004});
        exp_q.push_back('{addr: 5'd2, data: 32'h22220002});
        exp_q.push_back('{addr: 5'd1, data: 32'h11110001});
        cyc = 0;
        while ((alu_valid_i | lsu_valid_i | mdu_valid_i) && cyc < 8) begin
            sample();
            a = alu_ready_o; l = lsu_ready_o; m = mdu_ready_o;
            if (a) chk("b_alu_ready_cycle", 32'(cyc), 32'd2);
            step();
            if (a) alu_valid_i = 1'b0;
            if (l) lsu_valid_i = 1'b0;
            if (m) mdu_valid_i = 1'b0;
            cyc++;
        end
        chk("b_all_accepted", 32'({alu_valid_i, lsu_valid_i, mdu_valid_i}), 32'd0);

        // Issue r7 on the same edge its write commits: set wins
        issue_valid_i = 1'b1; issue_rd_i = 5'd7;
        step();
        issue_valid_i = 1'b0; issue_rd_i = 5'd0;
        alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 32'h00000077;
        exp_q.push_back('{addr: 5'd7, data: 32'h00000077});
        step();
        alu_valid_i = 1'b0;
        issue_valid_i = 1'b1; issue_rd_i = 5'd7;
        step();
        issue_valid_i = 1'b0; issue_rd_i = 5'd0;
        chk_rs1_i = 5'd7;
        sample();
        chk("c_busy7", 32'(busy_o[7]), 32'd1);
        chk("c_hazard7", 32'(hazard_o), 32'd1);
        chk_rs1_i = 5'd0;

        // Flush with r5, r9 busy and r9 issued on the flush edge
        step();
        issue_valid_i = 1'b1; issue_rd_i = 5'd5;
        step();
        issue_rd_i = 5'd9;
        step();
        flush_i = 1'b1;
        sample();
        chk("d_busy_pre", busy_o, 32'h000002A0);
        step();
        flush_i = 1'b0; issue_valid_i = 1'b0; issue_rd_i = 5'd0;
        chk_rs2_i = 5'd9;
        sample();
        chk("d_busy_post", busy_o, 32'h00000200);
        chk("d_hazard9", 32'(hazard_o), 32'd1);
        chk_rs2_i = 5'd0;
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        sample();
        chk("d_busy_clear", busy_o, 32'd0);

        // In-flight write to r12 (forwarding when enabled)
        step();
        issue_valid_i = 1'b1; issue_rd_i = 5'd12;
        step();
        issue_valid_i = 1'b0; issue_rd_i = 5'd0;
        alu_valid_i = 1'b1; alu_rd_i = 5'd12; alu_data_i = 32'h00001234;
        exp_q.push_back('{addr: 5'd12, data: 32'h00001234});
        step();
        alu_valid_i = 1'b0;
        chk_rs1_i = 5'd12;
`ifdef WB_BYPASS_EN
        fwd_raddr1_i = 5'd12; fwd_raddr2_i = 5'd0;
`endif
        sample();
        chk("e_busy12", 32'(busy_o[12]), 32'd1);
`ifdef WB_BYPASS_EN
        chk("e_hazard12", 32'(hazard_o), 32'd0);
        chk("e_fwd_hit1", 32'(fwd_hit1_o), 32'd1);
        chk("e_fwd_data1", fwd_data1_o, 32'h00001234);
        chk("e_fwd_hit2", 32'(fwd_hit2_o), 32'd0);
`else
        chk("e_hazard12", 32'(hazard_o), 32'd1);
`endif
        step();
        sample();
        chk("e_busy12_after", 32'(busy_o[12]), 32'd0);
        chk("e_hazard_after", 32'(hazard_o), 32'd0);
        chk_rs1_i = 5'd0;

        // Reset asserted while waddr_o=5 is pending
        step();
        issue_valid_i = 1'b1; issue_rd_i = 5'd5;
        step();
        issue_valid_i = 1'b0; issue_rd_i = 5'd0;
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'h00000055;
        exp_q.push_back('{addr: 5'd5, data: 32'h00000055});
        step();
        alu_valid_i = 1'b0;
        sample();
        chk("f_busy5_pre", 32'(busy_o[5]), 32'd1);
        #1;
        rst_i = 1'b0;
        #1;
        chk("f_rst_waddr", 32'(waddr_o), 32'd0);
        chk("f_rst_wdata", wdata_o, 32'd0);
        chk("f_rst_busy", busy_o, 32'd0);
        alu_valid_i = 1'b1; alu_rd_i = 5'd6;
        #1;
        chk("f_rst_ready", 32'(alu_ready_o), 32'd0);
        alu_valid_i = 1'b0;
        step();
        rst_i = 1'b1;
        sample();
        chk("f_idle_waddr", 32'(waddr_o), 32'd0);
        chk("f_idle_wdata", wdata_o, 32'd0);

        repeat (3) step();
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
